// File: rtl/cmp_issue_station_if.sv
// Dispatch, CDB and comparator-port bundle for cmp_issue_station.
// The slave modport is the station; the master modport is its environment.
interface cmp_issue_station_if #(parameter int TAG_W = 4);
  logic             disp_valid;
  logic             disp_ready;
  logic [3:0]       disp_control;
  logic [63:0]      disp_a;
  logic [63:0]      disp_b;
  logic             disp_a_rdy;
  logic             disp_b_rdy;
  logic [TAG_W-1:0] disp_a_tag;
  logic [TAG_W-1:0] disp_b_tag;
  logic [TAG_W-1:0] disp_dest_tag;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [63:0]      cdb_data;
  logic [3:0]       fu_control;
  logic [63:0]      fu_a;
  logic [63:0]      fu_b;
  logic [TAG_W-1:0] fu_dest_tag;
  logic             fu_enable;
  logic             fu_busy;

  modport master (
    output disp_valid, disp_control, disp_a, disp_b, disp_a_rdy, disp_b_rdy,
           disp_a_tag, disp_b_tag, disp_dest_tag, cdb_valid, cdb_tag, cdb_data, fu_busy,
    input  disp_ready, fu_control, fu_a, fu_b, fu_dest_tag, fu_enable
  );

  modport slave (
    input  disp_valid, disp_control, disp_a, disp_b, disp_a_rdy, disp_b_rdy,
           disp_a_tag, disp_b_tag, disp_dest_tag, cdb_valid, cdb_tag, cdb_data, fu_busy,
    output disp_ready, fu_control, fu_a, fu_b, fu_dest_tag, fu_enable
  );
endinterface

// File: rtl/cmp_issue_station.sv
// Reservation station in front of the comparator: holds micro-ops until both operands arrive, issues one per cycle.
// Optional macro CMP_RS_AGE_SELECT_EN selects the oldest eligible entry; default selects the lowest index.
module cmp_issue_station #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  cmp_issue_station_if.slave     bus,
  output logic [$clog2(DEPTH):0] count
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic             valid_q [DEPTH];
  logic             valid_d [DEPTH];
  logic [3:0]       ctrl_q  [DEPTH];
  logic [3:0]       ctrl_d  [DEPTH];
  logic [63:0]      a_q     [DEPTH];
  logic [63:0]      a_d     [DEPTH];
  logic [63:0]      b_q     [DEPTH];
  logic [63:0]      b_d     [DEPTH];
  logic             a_rdy_q [DEPTH];
  logic             a_rdy_d [DEPTH];
  logic             b_rdy_q [DEPTH];
  logic             b_rdy_d [DEPTH];
  logic [TAG_W-1:0] a_tag_q [DEPTH];
  logic [TAG_W-1:0] a_tag_d [DEPTH];
  logic [TAG_W-1:0] b_tag_q [DEPTH];
  logic [TAG_W-1:0] b_tag_d [DEPTH];
  logic [TAG_W-1:0] dest_q  [DEPTH];
  logic [TAG_W-1:0] dest_d  [DEPTH];
`ifdef CMP_RS_AGE_SELECT_EN
  // Age is the rank among valid entries: 0 is the oldest.
  logic [IDX_W-1:0] age_q   [DEPTH];
  logic [IDX_W-1:0] age_d   [DEPTH];
  logic [IDX_W-1:0] best_age;
  logic [CNT_W-1:0] age_base;
`endif

  logic [CNT_W-1:0] count_q, count_d;
  logic [3:0]       fu_control_q, fu_control_d;
  logic [63:0]      fu_a_q, fu_a_d;
  logic [63:0]      fu_b_q, fu_b_d;
  logic [TAG_W-1:0] fu_dest_tag_q, fu_dest_tag_d;
  logic             fu_enable_q, fu_enable_d;

  logic             sel_found, free_found, accept, issue;
  logic [IDX_W-1:0] sel_idx, free_idx;
  logic             da_hit, db_hit;

  assign bus.disp_ready  = (count_q < CNT_W'(DEPTH));
  assign bus.fu_control  = fu_control_q;
  assign bus.fu_a        = fu_a_q;
  assign bus.fu_b        = fu_b_q;
  assign bus.fu_dest_tag = fu_dest_tag_q;
  assign bus.fu_enable   = fu_enable_q;
  assign count           = count_q;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
`ifdef CMP_RS_AGE_SELECT_EN
    best_age  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && a_rdy_q[i] && b_rdy_q[i] && (!sel_found || age_q[i] < best_age)) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        best_age  = age_q[i];
      end
    end
`else
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid_q[i] && a_rdy_q[i] && b_rdy_q[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
`endif
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    accept = bus.disp_valid & bus.disp_ready & free_found & ~flush;
    issue  = sel_found & ~bus.fu_busy & ~flush;
    // A broadcast in the dispatch cycle must not be missed by the incoming op.
    da_hit = bus.cdb_valid & ~bus.disp_a_rdy & (bus.disp_a_tag == bus.cdb_tag);
    db_hit = bus.cdb_valid & ~bus.disp_b_rdy & (bus.disp_b_tag == bus.cdb_tag);
`ifdef CMP_RS_AGE_SELECT_EN
    age_base = count_q - CNT_W'(issue);
`endif
    for (int i = 0; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i];
      ctrl_d[i]  = ctrl_q[i];
      a_d[i]     = a_q[i];
      b_d[i]     = b_q[i];
      a_rdy_d[i] = a_rdy_q[i];
      b_rdy_d[i] = b_rdy_q[i];
      a_tag_d[i] = a_tag_q[i];
      b_tag_d[i] = b_tag_q[i];
      dest_d[i]  = dest_q[i];
`ifdef CMP_RS_AGE_SELECT_EN
      age_d[i]   = age_q[i];
      if (issue && valid_q[i] && age_q[i] > age_q[sel_idx])
        age_d[i] = age_q[i] - IDX_W'(1);
`endif
      if (bus.cdb_valid && valid_q[i]) begin
        if (!a_rdy_q[i] && a_tag_q[i] == bus.cdb_tag) begin
          a_d[i]     = bus.cdb_data;
          a_rdy_d[i] = 1'b1;
        end
        if (!b_rdy_q[i] && b_tag_q[i] == bus.cdb_tag) begin
          b_d[i]     = bus.cdb_data;
          b_rdy_d[i] = 1'b1;
        end
      end
      if (issue && sel_idx == IDX_W'(i))
        valid_d[i] = 1'b0;
      if (accept && free_idx == IDX_W'(i)) begin
        valid_d[i] = 1'b1;
        ctrl_d[i]  = bus.disp_control;
        a_d[i]     = da_hit ? bus.cdb_data : bus.disp_a;
        b_d[i]     = db_hit ? bus.cdb_data : bus.disp_b;
        a_rdy_d[i] = bus.disp_a_rdy | da_hit;
        b_rdy_d[i] = bus.disp_b_rdy | db_hit;
        a_tag_d[i] = bus.disp_a_tag;
        b_tag_d[i] = bus.disp_b_tag;
        dest_d[i]  = bus.disp_dest_tag;
`ifdef CMP_RS_AGE_SELECT_EN
        age_d[i]   = age_base[IDX_W-1:0];
`endif
      end
      if (flush)
        valid_d[i] = 1'b0;
    end
    count_d = flush ? '0 : (count_q + CNT_W'(accept) - CNT_W'(issue));

    fu_enable_d   = issue;
    fu_control_d  = fu_control_q;
    fu_a_d        = fu_a_q;
    fu_b_d        = fu_b_q;
    fu_dest_tag_d = fu_dest_tag_q;
    if (issue) begin
      fu_control_d  = ctrl_q[sel_idx];
      fu_a_d        = a_q[sel_idx];
      fu_b_d        = b_q[sel_idx];
      fu_dest_tag_d = dest_q[sel_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        ctrl_q[i]  <= '0;
        a_q[i]     <= '0;
        b_q[i]     <= '0;
        a_rdy_q[i] <= 1'b0;
        b_rdy_q[i] <= 1'b0;
        a_tag_q[i] <= '0;
        b_tag_q[i] <= '0;
        dest_q[i]  <= '0;
`ifdef CMP_RS_AGE_SELECT_EN
        age_q[i]   <= '0;
`endif
      end
      count_q       <= '0;
      fu_control_q  <= '0;
      fu_a_q        <= '0;
      fu_b_q        <= '0;
      fu_dest_tag_q <= '0;
      fu_enable_q   <= 1'b0;
    end else begin
      valid_q       <= valid_d;
      ctrl_q        <= ctrl_d;
      a_q           <= a_d;
      b_q           <= b_d;
      a_rdy_q       <= a_rdy_d;
      b_rdy_q       <= b_rdy_d;
      a_tag_q       <= a_tag_d;
      b_tag_q       <= b_tag_d;
      dest_q        <= dest_d;
`ifdef CMP_RS_AGE_SELECT_EN
      age_q         <= age_d;
`endif
      count_q       <= count_d;
      fu_control_q  <= fu_control_d;
      fu_a_q        <= fu_a_d;
      fu_b_q        <= fu_b_d;
      fu_dest_tag_q <= fu_dest_tag_d;
      fu_enable_q   <= fu_enable_d;
    end
  end
endmodule

// File: tb/tb_cmp_issue_station.sv
// Scoreboard bench for cmp_issue_station: a slot/sequence-number model predicts issues, a negedge monitor checks them.
module tb_cmp_issue_station;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic [2:0] count;

  cmp_issue_station_if #(.TAG_W(TAG_W)) bus();

  cmp_issue_station #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus),
    .count (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit [3:0]  ctl;
    bit [63:0] a;
    bit [63:0] b;
    bit [3:0]  dt;
  } iss_t;

  typedef struct {
    bit          v;
    bit [3:0]    ctl;
    bit [63:0]   a;
    bit [63:0]   b;
    bit          ar;
    bit          br;
    bit [3:0]    at;
    bit [3:0]    bt;
    bit [3:0]    dt;
    int unsigned seq;
  } ent_t;

  ent_t        m [DEPTH];
  int          mcount;
  int unsigned seq_ctr;
  iss_t        exp_q [$];
  bit          pend_v;
  iss_t        pend;
  iss_t        mon_e;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic mreset();
    for (int i = 0; i < DEPTH; i++) m[i].v = 1'b0;
    mcount  = 0;
    seq_ctr = 0;
    pend_v  = 1'b0;
  endtask

  // One clock of the station's behaviour, evaluated on the inputs as currently driven.
  task automatic model_step();
    int sel = -1;
    int slot = -1;
    pend_v = 1'b0;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) m[i].v = 1'b0;
      mcount = 0;
      return;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (m[i].v && m[i].ar && m[i].br) begin
`ifdef CMP_RS_AGE_SELECT_EN
        if (sel < 0 || m[i].seq < m[sel].seq) sel = i;
`else
        if (sel < 0) sel = i;
`endif
      end
    end
    if (bus.disp_valid && mcount < DEPTH)
      for (int i = 0; i < DEPTH; i++) if (!m[i].v && slot < 0) slot = i;
    if (bus.cdb_valid) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (m[i].v && !m[i].ar && m[i].at == bus.cdb_tag) begin m[i].a = bus.cdb_data; m[i].ar = 1'b1; end
        if (m[i].v && !m[i].br && m[i].bt == bus.cdb_tag) begin m[i].b = bus.cdb_data; m[i].br = 1'b1; end
      end
    end
    if (sel >= 0 && !bus.fu_busy) begin
      pend_v = 1'b1;
      pend   = '{ctl: m[sel].ctl, a: m[sel].a, b: m[sel].b, dt: m[sel].dt};
      m[sel].v = 1'b0;
    end
    if (slot >= 0) begin
      m[slot].v   = 1'b1;
      m[slot].ctl = bus.disp_control;
      m[slot].at  = bus.disp_a_tag;
      m[slot].bt  = bus.disp_b_tag;
      m[slot].dt  = bus.disp_dest_tag;
      m[slot].ar  = bus.disp_a_rdy || (bus.cdb_valid && bus.disp_a_tag == bus.cdb_tag);
      m[slot].br  = bus.disp_b_rdy || (bus.cdb_valid && bus.disp_b_tag == bus.cdb_tag);
      m[slot].a   = bus.disp_a_rdy ? bus.disp_a : bus.cdb_data;
      m[slot].b   = bus.disp_b_rdy ? bus.disp_b : bus.cdb_data;
      m[slot].seq = seq_ctr++;
    end
    mcount = 0;
    for (int i = 0; i < DEPTH; i++) if (m[i].v) mcount++;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    if (pend_v) exp_q.push_back(pend);
    chk("count", count, mcount);
    chk("disp_ready", bus.disp_ready, mcount < DEPTH);
  endtask

  task automatic idle_inputs();
    flush             = 1'b0;
    bus.disp_valid    = 1'b0;
    bus.disp_control  = '0;
    bus.disp_a        = '0;
    bus.disp_b        = '0;
    bus.disp_a_rdy    = 1'b0;
    bus.disp_b_rdy    = 1'b0;
    bus.disp_a_tag    = '0;
    bus.disp_b_tag    = '0;
    bus.disp_dest_tag = '0;
    bus.cdb_valid     = 1'b0;
    bus.cdb_tag       = '0;
    bus.cdb_data      = '0;
  endtask

  task automatic disp(bit [3:0] ctl, bit [63:0] a, bit [63:0] b, bit ar, bit br,
                      bit [3:0] at, bit [3:0] bt, bit [3:0] dt);
    bus.disp_valid    = 1'b1;
    bus.disp_control  = ctl;
    bus.disp_a        = a;
    bus.disp_b        = b;
    bus.disp_a_rdy    = ar;
    bus.disp_b_rdy    = br;
    bus.disp_a_tag    = at;
    bus.disp_b_tag    = bt;
    bus.disp_dest_tag = dt;
  endtask

  task automatic cdb(bit [3:0] tag, bit [63:0] data);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = tag;
    bus.cdb_data  = data;
  endtask

  task automatic rand_cycle();
    idle_inputs();
    flush = ($urandom_range(0, 49) == 0);
    if ($urandom_range(0, 99) < 60)
      disp(4'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom),
           4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 4'($urandom));
    if ($urandom_range(0, 99) < 40)
      cdb(4'($urandom_range(0, 7)), {$urandom, $urandom});
    bus.fu_busy = ($urandom_range(0, 99) < 30);
    cycle();
  endtask

  // Monitor: every fu_enable pulse must match the oldest outstanding prediction.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.fu_enable) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL fu_enable_unexpected actual=1 required=0");
          end else begin
            mon_e = exp_q.pop_front();
            chk("fu_control", bus.fu_control, mon_e.ctl);
            chk("fu_a", bus.fu_a, mon_e.a);
            chk("fu_b", bus.fu_b, mon_e.b);
            chk("fu_dest_tag", bus.fu_dest_tag, mon_e.dt);
          end
        end else if (exp_q.size() != 0) begin
          checks++;
          failures++;
          $display("FAIL fu_enable_missing actual=0 required=1");
          exp_q.delete();
        end
      end
    end
  end

  initial begin
    idle_inputs();
    bus.fu_busy = 1'b0;
    mreset();
    #2;
    chk("rst_count", count, 0);
    chk("rst_disp_ready", bus.disp_ready, 1);
    chk("rst_fu_enable", bus.fu_enable, 0);
    chk("rst_fu_a", bus.fu_a, 0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Both operands ready: issue at minimum latency.
    disp(4'h3, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 1, 1, 0, 0, 4'h7);
    cycle();
    idle_inputs();
    cycle();
    chk("min_lat_enable", bus.fu_enable, 1);
    chk("min_lat_dest", bus.fu_dest_tag, 4'h7);
    repeat (2) cycle();
    chk("single_pulse", bus.fu_enable, 0);

    // Operand b waits on tag 5; tag 6 must not wake it.
    disp(4'h5, 64'hA, 64'h0, 1, 0, 0, 4'h5, 4'h2);
    cycle();
    idle_inputs();
    cycle();
    cdb(4'h6, 64'h1234);
    cycle();
    idle_inputs();
    chk("tag6_no_issue", bus.fu_enable, 0);
    cycle();
    cdb(4'h5, 64'h0000_0000_DEAD_BEEF);
    cycle();
    idle_inputs();
    cycle();
    chk("wake_enable", bus.fu_enable, 1);
    chk("wake_fu_b", bus.fu_b, 64'hDEAD_BEEF);
    repeat (2) cycle();

    // Same-cycle dispatch and broadcast.
    disp(4'h9, 64'h0, 64'h77, 0, 1, 4'h3, 0, 4'h4);
    cdb(4'h3, 64'hCAFE_F00D_0000_0001);
    cycle();
    idle_inputs();
    cycle();
    chk("same_cycle_enable", bus.fu_enable, 1);
    chk("same_cycle_fu_a", bus.fu_a, 64'hCAFE_F00D_0000_0001);
    repeat (2) cycle();

    // Fill while busy, attempt a fifth, then drain back to back.
    bus.fu_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      disp(4'(i + 1), 64'(i * 16 + 1), 64'(i * 16 + 2), 1, 1, 0, 0, 4'(i + 8));
      cycle();
    end
    idle_inputs();
    chk("full_disp_ready", bus.disp_ready, 0);
    chk("full_count", count, 4);
    bus.fu_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("drain_enable", bus.fu_enable, 1);
    end
    repeat (2) cycle();

    // Flush with three entries, one of them eligible.
    bus.fu_busy = 1'b1;
    disp(4'h1, 64'h10, 64'h20, 1, 1, 0, 0, 4'h1);
    cycle();
    disp(4'h2, 64'h0, 64'h20, 0, 1, 4'h9, 0, 4'h2);
    cycle();
    disp(4'h3, 64'h10, 64'h0, 1, 0, 0, 4'hA, 4'h3);
    cycle();
    idle_inputs();
    bus.fu_busy = 1'b0;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_no_enable", bus.fu_enable, 0);
    repeat (2) cycle();

    repeat (300) rand_cycle();

    // Asynchronous reset between edges.
    #2 rst_n = 1'b0;
    #1;
    chk("arst_fu_enable", bus.fu_enable, 0);
    chk("arst_fu_a", bus.fu_a, 0);
    chk("arst_fu_b", bus.fu_b, 0);
    chk("arst_fu_control", bus.fu_control, 0);
    chk("arst_fu_dest_tag", bus.fu_dest_tag, 0);
    chk("arst_count", count, 0);
    chk("arst_disp_ready", bus.disp_ready, 1);
    exp_q.delete();
    mreset();
    idle_inputs();
    bus.fu_busy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    repeat (200) rand_cycle();

    idle_inputs();
    bus.fu_busy = 1'b0;
    repeat (10) cycle();
    @(negedge clk);
    #1;
    chk("drain_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
